// File: rtl/noise_pkg.sv
// Shared constants and FSM encoding for the noise memory fill sequencer.
package noise_pkg;

   localparam int unsigned cBANKS     = 16;
   localparam int unsigned cADDR_BITS = 3;
   localparam logic [31:0] cSEED      = 32'hACE1_2468;
   localparam logic [31:0] cTAPS      = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/noise_lfsr_step.sv
// One right-shift Galois LFSR step; purely combinational.
module noise_lfsr_step #(
   parameter logic [31:0] pTAPS = noise_pkg::cTAPS
) (
   input  logic [31:0] i_state,
   output logic [31:0] o_next
);

   always_comb begin
      o_next = (i_state >> 1) ^ (i_state[0] ? pTAPS : '0);
   end

endmodule

// File: rtl/noise_fill_ctrl.sv
// Write-side sequencer: fills every address of the banked noise memories
// with successive LFSR states, then pulses done.
module noise_fill_ctrl
   import noise_pkg::*;
#(
   parameter int unsigned pBANKS     = cBANKS,
   parameter int unsigned pADDR_BITS = cADDR_BITS,
   parameter logic [31:0] pSEED      = cSEED,
   parameter logic [31:0] pTAPS      = cTAPS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  I_start,
   input  logic [pBANKS-1:0]     I_bank_mask,
   input  logic                  I_hold,
   input  logic                  I_seed_load,
   input  logic [31:0]           I_seed,
   output logic                  O_busy,
   output logic                  O_done,
   output logic                  O_wr_en,
   output logic [pBANKS-1:0]     O_enable,
   output logic [pADDR_BITS-1:0] O_wr_addr,
   output logic [31:0]           O_lfsr_state
);

   state_t                  r_state;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_wr_en;
   logic [pBANKS-1:0]       r_enable;
   logic [pADDR_BITS-1:0]   r_addr;
   logic [31:0]             r_lfsr;
   logic [31:0]             w_lfsr_next;
   logic [31:0]             w_seed;

   noise_lfsr_step #(.pTAPS(pTAPS)) u_step (
      .i_state (r_lfsr),
      .o_next  (w_lfsr_next)
   );

   assign w_seed = (I_seed == '0) ? pSEED : I_seed;

   // r_wr_en marks the cycle whose write is on the bus; address and LFSR
   // advance only at the end of such a cycle, so a hold freezes both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_wr_en  <= 1'b0;
         r_enable <= '0;
         r_addr   <= '0;
         r_lfsr   <= pSEED;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (I_seed_load)
                  r_lfsr <= w_seed;
               if (I_start) begin
                  r_busy <= 1'b1;
                  r_addr <= '0;
                  if (I_bank_mask != '0) begin
                     r_state  <= ST_FILL;
                     r_wr_en  <= 1'b1;
                     r_enable <= I_bank_mask;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_FILL: begin
               if (r_wr_en && (r_addr == '1)) begin
                  r_lfsr   <= w_lfsr_next;
                  r_addr   <= r_addr + 1'b1;
                  r_state  <= ST_DONE;
                  r_wr_en  <= 1'b0;
                  r_enable <= '0;
                  r_done   <= 1'b1;
               end else begin
                  if (r_wr_en) begin
                     r_lfsr <= w_lfsr_next;
                     r_addr <= r_addr + 1'b1;
                  end
                  r_wr_en <= ~I_hold;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
               r_wr_en  <= 1'b0;
               r_enable <= '0;
            end
         endcase
      end
   end

   assign O_busy       = r_busy;
   assign O_done       = r_done;
   assign O_wr_en      = r_wr_en;
   assign O_enable     = r_enable;
   assign O_wr_addr    = r_addr;
   assign O_lfsr_state = r_lfsr;

endmodule

// File: tb/tb_noise_fill_ctrl.sv
// Directed bench for noise_fill_ctrl with a cycle-level expectation model.
module tb_noise_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        I_start;
   logic [15:0] I_bank_mask;
   logic        I_hold;
   logic        I_seed_load;
   logic [31:0] I_seed;
   logic        O_busy;
   logic        O_done;
   logic        O_wr_en;
   logic [15:0] O_enable;
   logic [2:0]  O_wr_addr;
   logic [31:0] O_lfsr_state;

   logic [31:0] m_lfsr;
   logic [31:0] m_next;
   logic [31:0] obs [8];
   int          n_checks = 0;
   int          n_pass   = 0;

   localparam logic [31:0] SEED = 32'hACE1_2468;

   noise_fill_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .I_start      (I_start),
      .I_bank_mask  (I_bank_mask),
      .I_hold       (I_hold),
      .I_seed_load  (I_seed_load),
      .I_seed       (I_seed),
      .O_busy       (O_busy),
      .O_done       (O_done),
      .O_wr_en      (O_wr_en),
      .O_enable     (O_enable),
      .O_wr_addr    (O_wr_addr),
      .O_lfsr_state (O_lfsr_state)
   );

   noise_lfsr_step #(.pTAPS(32'h8020_0003)) u_model (
      .i_state (m_lfsr),
      .o_next  (m_next)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 is the start cycle; hold driven in cycles [hold_from, hold_from+hold_n)
   // suppresses the write one cycle later.
   task automatic run_fill(input logic [15:0] mask, input int hold_from, input int hold_n,
                           input int exp_done, input bit seed_in_fill);
      int  wr;
      bit  exp_we;
      I_start     = 1'b1;
      I_bank_mask = mask;
      tick;
      I_start     = 1'b0;
      I_seed_load = 1'b0;
      wr = 0;
      for (int c = 1; c <= exp_done + 1; c++) begin
         exp_we = (c < exp_done) && (mask != 0) &&
                  !((c - 1 >= hold_from) && (c - 1 < hold_from + hold_n));
         chk("wr_en", O_wr_en, exp_we);
         chk("done", O_done, c == exp_done);
         chk("busy", O_busy, c <= exp_done);
         chk("enable", O_enable, (c < exp_done) ? mask : 16'h0);
         chk("lfsr", O_lfsr_state, m_lfsr);
         if (exp_we) begin
            chk("addr", O_wr_addr, wr);
            if (wr < 8) obs[wr] = O_lfsr_state;
            m_lfsr = m_next;
            wr++;
         end
         I_hold      = (c >= hold_from) && (c < hold_from + hold_n);
         I_seed_load = seed_in_fill && (c == 3);
         I_seed      = 32'hDEAD_BEEF;
         if (c <= exp_done) tick;
      end
      I_hold      = 1'b0;
      I_seed_load = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; I_start = 1'b0; I_bank_mask = '0; I_hold = 1'b0;
      I_seed_load = 1'b0; I_seed = '0;
      tick; tick;
      chk("rst_lfsr", O_lfsr_state, SEED);
      chk("rst_addr", O_wr_addr, 0);
      chk("rst_busy", O_busy, 0);
      chk("rst_done", O_done, 0);
      chk("rst_wr_en", O_wr_en, 0);
      chk("rst_enable", O_enable, 0);
      rst_n = 1'b1;
      tick;
      chk("idle_lfsr", O_lfsr_state, SEED);

      I_seed_load = 1'b1; I_seed = 32'h0000_0001;
      tick;
      I_seed_load = 1'b0;
      chk("seed1", O_lfsr_state, 32'h0000_0001);
      m_lfsr = 32'h0000_0001;
      run_fill(16'hFFFF, 0, 0, 9, 1'b0);
      chk("w0", obs[0], 32'h0000_0001);
      chk("w1", obs[1], 32'h8020_0003);
      chk("w2", obs[2], 32'hC030_0002);

      run_fill(16'h0000, 0, 0, 1, 1'b0);

      run_fill(16'h00A5, 4, 3, 12, 1'b1);

      I_seed_load = 1'b1; I_seed = 32'h0;
      tick;
      I_seed_load = 1'b0;
      chk("seed0", O_lfsr_state, SEED);
      m_lfsr = SEED;

      I_seed_load = 1'b1; I_seed = 32'h1234_5678;
      m_lfsr = 32'h1234_5678;
      run_fill(16'h8001, 0, 0, 9, 1'b0);
      chk("seed_start_w0", obs[0], 32'h1234_5678);

      I_start = 1'b1; I_bank_mask = 16'hFFFF;
      tick;
      I_start = 1'b0;
      for (int c = 1; c < 5; c++) tick;
      chk("pre_rst_addr", O_wr_addr, 4);
      rst_n = 1'b0;
      #1;
      chk("ab_busy", O_busy, 0);
      chk("ab_wr_en", O_wr_en, 0);
      chk("ab_enable", O_enable, 0);
      chk("ab_addr", O_wr_addr, 0);
      chk("ab_lfsr", O_lfsr_state, SEED);
      chk("ab_done", O_done, 0);
      tick;
      rst_n = 1'b1;
      tick;
      chk("post_done", O_done, 0);
      chk("post_busy", O_busy, 0);
      m_lfsr = SEED;
      run_fill(16'hFFFF, 0, 0, 9, 1'b0);
      chk("restart_w0", obs[0], SEED);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/noise_fill_ctrl.md
# noise_fill_ctrl

Write-side sequencer for the banked noise memories used by the ECC datapath's randomization logic. On each `I_start` it fills all eight addresses of the x/y/z noise memories. Every write cycle it presents a fresh 32-bit LFSR state, a write address and a per-bank enable mask. It also owns the LFSR seed, and signals completion with a single-cycle done pulse.

## Interface
- `pBANKS`, 16: number of noise memory banks; width of the enable mask.
- `pADDR_BITS`, 3: noise memory address width; a fill covers 2^pADDR_BITS addresses.
- `pSEED`, 32'hACE1_2468: reset seed, and the substitute when a zero seed is loaded.
- `pTAPS`, 32'h8020_0003: Galois tap mask for x^32+x^22+x^2+x+1.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `I_start` input 1: fill request; sampled only in IDLE.
- `I_bank_mask` input pBANKS: banks to write; latched when `I_start` is accepted.
- `I_hold` input 1: stall; freezes the fill in progress.
- `I_seed_load` input 1: load `I_seed` into the LFSR; accepted only in IDLE.
- `I_seed` input 32: seed value.
- `O_busy` output 1: high while the state is not IDLE.
- `O_done` output 1: one-cycle pulse when a fill completes.
- `O_wr_en` output 1: write strobe to the noise memories.
- `O_enable` output pBANKS: per-bank write enable; this is the latched mask.
- `O_wr_addr` output pADDR_BITS: write address, shared by the rx/ry/rz memories.
- `O_lfsr_state` output 32: write data seed; the memories derive the x/y/z/bank variants from it.

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE to FILL:
  - On `I_start`=1 with `I_bank_mask`≠0, the mask is latched and the address cleared.
  - On `I_start`=1 with `I_bank_mask`=0, the FSM goes directly to DONE and no writes occur.
- FILL, `I_hold`=0:
  - `O_wr_en`=1 at the current address, carrying the current LFSR state.
  - The LFSR steps, and the address increments.
  - After the write to the address of all ones, the FSM goes to DONE.
- FILL, `I_hold`=1: `O_wr_en`=0; address and LFSR hold.
- DONE: `O_done`=1 for exactly one cycle, then IDLE.
- LFSR step (right-shift Galois): next = (s>>1) ^ (s[0] ? pTAPS : 0).
  - The LFSR steps only on write cycles; it never steps in IDLE or during a hold.
- Seed load:
  - Takes effect in IDLE only and is ignored otherwise.
  - A zero seed is replaced by `pSEED`, so the LFSR can never be all zeros.
  - If `I_seed_load` and `I_start` arrive in the same cycle, the seed is loaded first, so the first write of that fill uses the new seed.
- `I_start` while busy is ignored; it is neither queued nor counted.
- The address wraps 7→0 internally when the fill ends; the next fill restarts at 0 regardless.
- `rst_n` low during a fill:
  - The fill is aborted immediately and the FSM returns to IDLE.
  - No done pulse is produced.
  - The LFSR returns to `pSEED`.

## Timing
- All outputs are registered.
- Reset values:
  - `O_busy`, `O_done`, `O_wr_en` are 0.
  - `O_enable` is 0, `O_wr_addr` is 0, `O_lfsr_state` is `pSEED`.
- `I_start` is sampled in cycle 0. Writes to addresses 0..7 appear in cycles 1..8, and `O_done` pulses in cycle 9.
- Each hold cycle adds one cycle of latency.
- `O_busy` is high in cycles 1..9, and low again in cycle 10, when a new `I_start` can be accepted.
- With a zero mask: `O_busy` and `O_done` are both high in cycle 1 only.
- `O_enable` is stable for the whole fill, and is 0 outside FILL.

## Structure
- Package `noise_pkg`: `pBANKS`, `pADDR_BITS`, default seed, tap constant, and the FSM state encoding (IDLE=0, FILL=1, DONE=2).
- Sub-module `noise_lfsr_step`: purely combinational one-step Galois update, parameterised on taps. It is reused by the bench's reference model.
- Top level: FSM, address counter, mask register, LFSR register, and seed-load logic.

## Test plan
- Reset then release: `O_lfsr_state`=32'hACE1_2468, `O_wr_addr`=0, all strobes 0.
- Seed load 32'h0000_0001, then start with mask 16'hFFFF:
  - Writes at addresses 0,1,2 carry 32'h0000_0001, 32'h8020_0003, 32'hC030_0002.
  - `O_done` pulses in cycle 9.
- Mask 16'h0000: no `O_wr_en`; `O_done` pulses in cycle 1; LFSR is unchanged.
- Assert `I_hold` for 3 cycles during the write at address 4: the address-4 write is deferred, the LFSR holds, and `O_done` moves to cycle 12.
- Seed load of 0 → LFSR = `pSEED`. Seed load during FILL is ignored; LFSR continuity is checked against the model.
- Drop `rst_n` in cycle 5 of a fill: outputs go to reset values at once, no done pulse; a new start then restarts at address 0 from `pSEED`.
